// File: rtl/ttt_processor_array.sv
// Time-multiplexed array of token-threshold neurons: per-neuron state lives in
// register arrays, and a TICK sweep evaluates one neuron per cycle.
module ttt_processor_array #(
  parameter int unsigned NUM_PROCESSORS  = 10,
  parameter int unsigned NEW_TOKENS_BITS = 4,
  parameter int unsigned TOKENS_BITS     = 8,
  parameter int unsigned DURATION_BITS   = 8,
  parameter int unsigned PROG_WIDTH      = 8,
  localparam int unsigned ID_W = (NUM_PROCESSORS > 1) ? $clog2(NUM_PROCESSORS) : 1
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       instr_valid,
  output logic                       instr_ready,
  input  logic [2:0]                 instruction,
  input  logic [ID_W-1:0]            neuron_id,
  input  logic [PROG_WIDTH-1:0]      prog_data,
  input  logic [NEW_TOKENS_BITS-1:0] new_good_tokens,
  input  logic [NEW_TOKENS_BITS-1:0] new_bad_tokens,
  output logic                       out_valid,
  output logic [ID_W-1:0]            out_id,
  output logic [1:0]                 token_startstop,
  output logic                       sweep_done
);

  localparam int unsigned SUM_W = TOKENS_BITS + 1;
  localparam logic [TOKENS_BITS-1:0] TOK_MAX = '1;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_SWEEP = 1'b1;

  localparam logic [2:0] OP_GTH    = 3'd1;
  localparam logic [2:0] OP_BTH    = 3'd2;
  localparam logic [2:0] OP_DUR    = 3'd3;
  localparam logic [2:0] OP_CLEAR  = 3'd4;
  localparam logic [2:0] OP_TOKENS = 3'd5;
  localparam logic [2:0] OP_TICK   = 3'd6;

  localparam logic [1:0] SS_NONE  = 2'b00;
  localparam logic [1:0] SS_START = 2'b10;
  localparam logic [1:0] SS_STOP  = 2'b01;

  logic [0:0]      state_q, state_d;
  logic [ID_W-1:0] idx_q, idx_d;
  logic            ready_q, ready_d;
  logic            out_valid_q, out_valid_d;
  logic [ID_W-1:0] out_id_q, out_id_d;
  logic [1:0]      ss_q, ss_d;
  logic            done_q, done_d;

  logic [TOKENS_BITS-1:0]   good_q [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   good_d [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   bad_q  [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   bad_d  [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   gth_q  [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   gth_d  [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   bth_q  [NUM_PROCESSORS];
  logic [TOKENS_BITS-1:0]   bth_d  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] dur_q  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] dur_d  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] rem_q  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0] rem_d  [NUM_PROCESSORS];
  logic                     act_q  [NUM_PROCESSORS];
  logic                     act_d  [NUM_PROCESSORS];

  logic             accept;
  logic             id_ok;
  logic             last_idx;
  logic [SUM_W-1:0] good_sum;
  logic [SUM_W-1:0] bad_sum;

  assign instr_ready     = ready_q;
  assign out_valid       = out_valid_q;
  assign out_id          = out_id_q;
  assign token_startstop = ss_q;
  assign sweep_done      = done_q;

  // Instruction decode in IDLE, one-neuron-per-cycle evaluation in SWEEP.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    ready_d     = ready_q;
    out_valid_d = 1'b0;
    out_id_d    = out_id_q;
    ss_d        = SS_NONE;
    done_d      = 1'b0;
    for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
      good_d[i] = good_q[i];
      bad_d[i]  = bad_q[i];
      gth_d[i]  = gth_q[i];
      bth_d[i]  = bth_q[i];
      dur_d[i]  = dur_q[i];
      rem_d[i]  = rem_q[i];
      act_d[i]  = act_q[i];
    end

    accept   = instr_valid & ready_q;
    id_ok    = 32'(neuron_id) < NUM_PROCESSORS;
    last_idx = 32'(idx_q) == (NUM_PROCESSORS - 1);
    good_sum = SUM_W'(good_q[neuron_id]) + SUM_W'(new_good_tokens);
    bad_sum  = SUM_W'(bad_q[neuron_id]) + SUM_W'(new_bad_tokens);

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (instruction)
            OP_GTH:   if (id_ok) gth_d[neuron_id] = prog_data[TOKENS_BITS-1:0];
            OP_BTH:   if (id_ok) bth_d[neuron_id] = prog_data[TOKENS_BITS-1:0];
            OP_DUR:   if (id_ok) dur_d[neuron_id] = prog_data[DURATION_BITS-1:0];
            OP_CLEAR: begin
              if (id_ok) begin
                good_d[neuron_id] = '0;
                bad_d[neuron_id]  = '0;
                rem_d[neuron_id]  = '0;
                act_d[neuron_id]  = 1'b0;
              end
            end
            OP_TOKENS: begin
              // Carry out of the widened sum means the accumulator saturates.
              if (id_ok) begin
                good_d[neuron_id] = good_sum[TOKENS_BITS] ? TOK_MAX : good_sum[TOKENS_BITS-1:0];
                bad_d[neuron_id]  = bad_sum[TOKENS_BITS]  ? TOK_MAX : bad_sum[TOKENS_BITS-1:0];
              end
            end
            OP_TICK: begin
              state_d = S_SWEEP;
              idx_d   = '0;
              ready_d = 1'b0;
            end
            default: ;
          endcase
        end
      end
      S_SWEEP: begin
        if (act_q[idx_q] && (rem_q[idx_q] <= DURATION_BITS'(1))) begin
          act_d[idx_q] = 1'b0;
          rem_d[idx_q] = '0;
          out_valid_d  = 1'b1;
          ss_d         = SS_STOP;
        end else if (act_q[idx_q]) begin
          rem_d[idx_q] = rem_q[idx_q] - DURATION_BITS'(1);
        end else if ((good_q[idx_q] >= gth_q[idx_q]) && (bad_q[idx_q] < bth_q[idx_q])) begin
          act_d[idx_q]  = 1'b1;
          rem_d[idx_q]  = dur_q[idx_q];
          good_d[idx_q] = '0;
          bad_d[idx_q]  = '0;
          out_valid_d   = 1'b1;
          ss_d          = SS_START;
        end
        out_id_d = idx_q;
        if (last_idx) begin
          state_d = S_IDLE;
          idx_d   = '0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          idx_d = idx_q + ID_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        idx_d   = '0;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      ready_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_id_q    <= '0;
      ss_q        <= SS_NONE;
      done_q      <= 1'b0;
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
        good_q[i] <= '0;
        bad_q[i]  <= '0;
        gth_q[i]  <= '0;
        bth_q[i]  <= '0;
        dur_q[i]  <= '0;
        rem_q[i]  <= '0;
        act_q[i]  <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      ready_q     <= ready_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
      ss_q        <= ss_d;
      done_q      <= done_d;
      for (int i = 0; i < int'(NUM_PROCESSORS); i++) begin
        good_q[i] <= good_d[i];
        bad_q[i]  <= bad_d[i];
        gth_q[i]  <= gth_d[i];
        bth_q[i]  <= bth_d[i];
        dur_q[i]  <= dur_d[i];
        rem_q[i]  <= rem_d[i];
        act_q[i]  <= act_d[i];
      end
    end
  end

endmodule

// File: tb/tb_ttt_processor_array.sv
// Bench for ttt_processor_array: a sweep-level reference model predicts every
// output slot, plus directed scenarios with hand-computed expectations.
module tb_ttt_processor_array;

  localparam int N   = 10;
  localparam int IDW = 4;
  localparam int TMAX = 255;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic           instr_valid = 1'b0;
  logic           instr_ready;
  logic [2:0]     instruction = '0;
  logic [IDW-1:0] neuron_id = '0;
  logic [7:0]     prog_data = '0;
  logic [3:0]     new_good_tokens = '0;
  logic [3:0]     new_bad_tokens = '0;
  logic           out_valid;
  logic [IDW-1:0] out_id;
  logic [1:0]     token_startstop;
  logic           sweep_done;

  ttt_processor_array dut (
    .clock           (clock),
    .reset           (reset),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instruction     (instruction),
    .neuron_id       (neuron_id),
    .prog_data       (prog_data),
    .new_good_tokens (new_good_tokens),
    .new_bad_tokens  (new_bad_tokens),
    .out_valid       (out_valid),
    .out_id          (out_id),
    .token_startstop (token_startstop),
    .sweep_done      (sweep_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: neuron state as plain integers; a TICK resolves the whole
  // sweep at once and the outcomes are then released one slot per cycle.
  int m_good[N], m_bad[N], m_gth[N], m_bth[N], m_dur[N], m_rem[N];
  bit m_act[N];
  int plan[N];
  int m_left = 0;
  bit exp_valid = 1'b0, exp_done = 1'b0, exp_ready = 1'b1;
  int exp_id = 0, exp_ss = 0;

  function automatic void run_sweep();
    for (int i = 0; i < N; i++) begin
      plan[i] = 0;
      if (m_act[i] && m_rem[i] <= 1) begin
        m_act[i] = 1'b0; m_rem[i] = 0; plan[i] = 1;
      end else if (m_act[i]) begin
        m_rem[i] = m_rem[i] - 1;
      end else if (m_good[i] >= m_gth[i] && m_bad[i] < m_bth[i]) begin
        m_act[i] = 1'b1; m_rem[i] = m_dur[i]; m_good[i] = 0; m_bad[i] = 0; plan[i] = 2;
      end
    end
    m_left = N;
  endfunction

  function automatic void model_apply(input int op, input int id, input int data,
                                      input int g, input int b);
    if (op == 6) run_sweep();
    else if (id < N) begin
      case (op)
        1: m_gth[id] = data % 256;
        2: m_bth[id] = data % 256;
        3: m_dur[id] = data % 256;
        4: begin m_good[id] = 0; m_bad[id] = 0; m_rem[id] = 0; m_act[id] = 1'b0; end
        5: begin
          m_good[id] = (m_good[id] + g > TMAX) ? TMAX : m_good[id] + g;
          m_bad[id]  = (m_bad[id] + b > TMAX) ? TMAX : m_bad[id] + b;
        end
        default: ;
      endcase
    end
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        m_good[i] = 0; m_bad[i] = 0; m_gth[i] = 0; m_bth[i] = 0;
        m_dur[i] = 0; m_rem[i] = 0; m_act[i] = 1'b0;
      end
      m_left = 0;
      exp_valid = 1'b0; exp_id = 0; exp_ss = 0; exp_done = 1'b0; exp_ready = 1'b1;
    end else begin
      exp_valid = 1'b0; exp_ss = 0; exp_done = 1'b0;
      if (m_left > 0) begin
        exp_id    = N - m_left;
        exp_ss    = plan[exp_id];
        exp_valid = (exp_ss != 0);
        exp_done  = (m_left == 1);
        m_left    = m_left - 1;
      end else if (instr_valid) begin
        model_apply(int'(instruction), int'(neuron_id), int'(prog_data),
                    int'(new_good_tokens), int'(new_bad_tokens));
      end
      exp_ready = (m_left == 0);
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      check("instr_ready", int'(instr_ready), int'(exp_ready));
      check("out_valid", int'(out_valid), int'(exp_valid));
      check("token_startstop", int'(token_startstop), exp_ss);
      check("sweep_done", int'(sweep_done), int'(exp_done));
      if (exp_valid || !reset) check("out_id", int'(out_id), exp_id);
    end
  end

  // Event log for the directed literal expectations.
  int cyc = 0, ev_n = 0, last_id = -1, last_ss = 0, done_cyc = 0;
  always @(posedge clock) cyc++;
  always @(negedge clock) begin
    if (out_valid === 1'b1) begin
      ev_n++; last_id = int'(out_id); last_ss = int'(token_startstop);
    end
    if (sweep_done === 1'b1) done_cyc = cyc;
  end

  int acc_cyc = 0, n_wait = 0;

  task automatic issue(input int op, input int id, input int data = 0,
                       input int g = 0, input int b = 0);
    bit acc;
    acc = 1'b0;
    n_wait = 0;
    instruction = 3'(op); neuron_id = IDW'(id); prog_data = 8'(data);
    new_good_tokens = 4'(g); new_bad_tokens = 4'(b);
    instr_valid = 1'b1;
    for (int t = 0; t < 64 && !acc; t++) begin
      @(negedge clock);
      acc = instr_ready;
      if (!acc) n_wait++;
      @(posedge clock);
      #1;
    end
    instr_valid = 1'b0;
    acc_cyc = cyc;
    check("issue_accepted", int'(acc), 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic prog(input int id, input int gth, input int bth, input int dur);
    issue(1, id, gth); issue(2, id, bth); issue(3, id, dur);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, a;
    #2 reset = 1'b0;
    chk_en = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    idle(1);

    // Start event on neuron 3.
    prog(3, 5, 2, 3);
    issue(5, 3, 0, 5, 0);
    e0 = ev_n;
    issue(6, 0);
    a = acc_cyc;
    idle(12);
    check("A_events", ev_n - e0, 1);
    check("A_id", last_id, 3);
    check("A_is_start", last_ss, 2);
    check("A_done_latency", done_cyc - a, 10);
    check("A_model_good_cleared", m_good[3], 0);

    // Stop on the third tick after start.
    e0 = ev_n; issue(6, 0); idle(12);
    check("B_tick2_quiet", ev_n - e0, 0);
    issue(6, 0); idle(12);
    check("B_tick3_quiet", ev_n - e0, 0);
    issue(6, 0); idle(12);
    check("B_stop_events", ev_n - e0, 1);
    check("B_stop_id", last_id, 3);
    check("B_is_stop", last_ss, 1);

    // duration=0 stops on the next tick.
    prog(5, 1, 1, 0);
    issue(5, 5, 0, 1, 0);
    e0 = ev_n; issue(6, 0); idle(12);
    check("B0_start", last_ss, 2);
    check("B0_start_id", last_id, 5);
    issue(6, 0); idle(12);
    check("B0_events", ev_n - e0, 2);
    check("B0_stop", last_ss, 1);

    // Veto by bad tokens, then CLEAR and retry.
    prog(7, 5, 2, 2);
    issue(5, 7, 0, 8, 2);
    e0 = ev_n; issue(6, 0); idle(12);
    check("C_veto", ev_n - e0, 0);
    issue(4, 7);
    issue(5, 7, 0, 8, 0);
    issue(6, 0); idle(12);
    check("C_events", ev_n - e0, 1);
    check("C_id", last_id, 7);
    check("C_start", last_ss, 2);

    // Saturation of the good accumulator.
    prog(0, 255, 1, 1);
    repeat (20) issue(5, 0, 0, 15, 0);
    check("D_model_sat", m_good[0], 255);
    e0 = ev_n; issue(6, 0); idle(12);
    check("D_events", ev_n - e0, 1);
    check("D_id", last_id, 0);
    check("D_start", last_ss, 2);

    // Handshake held during a sweep, then out-of-range ids.
    issue(6, 0);
    issue(5, 1, 0, 3, 0);
    check("E_ready_low_cycles", n_wait, 10);
    issue(1, 12, 0); issue(2, 12, 9); issue(5, 12, 0, 15, 15); issue(4, 12);
    e0 = ev_n; issue(6, 0); idle(12);
    check("E_oor_quiet", ev_n - e0, 0);

    // Mid-sweep reset.
    prog(2, 1, 1, 200);
    issue(5, 2, 0, 1, 0);
    issue(6, 0); idle(12);
    issue(6, 0);
    repeat (4) @(posedge clock);
    #1 reset = 1'b0;
    #1;
    check("F_valid_now", int'(out_valid), 0);
    check("F_ready_now", int'(instr_ready), 1);
    check("F_done_now", int'(sweep_done), 0);
    check("F_ss_now", int'(token_startstop), 0);
    check("F_id_now", int'(out_id), 0);
    idle(2);
    reset = 1'b1;
    idle(1);
    e0 = ev_n; issue(6, 0); idle(12);
    check("F_no_events", ev_n - e0, 0);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      int op;
      op = int'($urandom_range(0, 9));
      if (op > 7) op = 5;
      issue(op, int'($urandom_range(0, 11)), int'($urandom_range(0, 6)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      if ($urandom_range(0, 3) == 0) idle(1);
    end
    idle(14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
